// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronizes up to 31 lines, raises meip_o for the
// lowest enabled pending source, and exposes claim/complete registers on a small slave port.
// Optional edge-triggered sources are built when EXT_IRQ_EDGE_DETECT_EN is defined.
module ext_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               ack_i,
    output logic               meip_o,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               wen_i,
    input  logic               ren_i,
    output logic [31:0]        rdata_o
);

    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_CLAIM    = 3'd2;
    localparam logic [2:0] REG_COMPLETE = 3'd3;
    localparam logic [2:0] REG_TRIGGER  = 3'd4;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [4:0]         claim_id_q, claim_id_d;
    logic               busy_q, busy_d;
    logic               meip_q, meip_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_IRQ-1:0] cand_vec;
    logic [4:0]         cand_idx;
    logic               cand_any;
    logic               claim_ok;
    logic [2:0]         sel;

    // Byte-lane bits of the address and the upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wdata_i, addr_i[1:0]};

    assign sel      = addr_i[4:2];
    assign cand_vec = pend_q & enable_q;
    assign cand_any = |cand_vec;
    assign claim_ok = ack_i & ~busy_q & cand_any;

    // Fixed priority: lowest index wins, so scan downward and let the last hit stand.
    always_comb begin
        cand_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (cand_vec[k]) begin
                cand_idx = 5'(k);
            end
        end
    end

`ifdef EXT_IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] sync3_q;
    logic [NUM_IRQ-1:0] trigger_q, trigger_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] claim_clr;

    assign rise = sync2_q & ~sync3_q;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_claim_clr
        assign claim_clr[gi] = claim_ok && (cand_idx == 5'(gi));
    end

    // A new rising edge outranks the clear from a same-cycle claim.
    always_comb begin
        pend_d = sync2_q;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (trigger_q[k]) begin
                pend_d[k] = rise[k] | (pend_q[k] & ~claim_clr[k]);
            end
        end
    end
`else
    always_comb begin
        pend_d = sync2_q;
    end
`endif

    always_comb begin
        enable_d   = enable_q;
        claim_id_d = claim_id_q;
        busy_d     = busy_q;
        rdata_d    = rdata_q;
`ifdef EXT_IRQ_EDGE_DETECT_EN
        trigger_d  = trigger_q;
`endif

        // Claim decisions use enable_q, so a same-cycle ENABLE write does not affect them.
        if (ack_i) begin
            if (claim_ok) begin
                claim_id_d = cand_idx + 5'd1;
                busy_d     = 1'b1;
            end else begin
                claim_id_d = 5'd0;
            end
        end

        if (wen_i) begin
            case (sel)
                REG_ENABLE: enable_d = wdata_i[NUM_IRQ-1:0];
                REG_COMPLETE: begin
                    if (busy_q && (wdata_i[4:0] == claim_id_q)) begin
                        busy_d = 1'b0;
                    end
                end
`ifdef EXT_IRQ_EDGE_DETECT_EN
                REG_TRIGGER: trigger_d = wdata_i[NUM_IRQ-1:0];
`endif
                default: ;
            endcase
        end

        meip_d = cand_any & ~busy_q;

        if (ren_i) begin
            case (sel)
                REG_PENDING: rdata_d = 32'(pend_q);
                REG_ENABLE:  rdata_d = 32'(enable_q);
                REG_CLAIM:   rdata_d = {busy_q, 26'd0, claim_id_q};
`ifdef EXT_IRQ_EDGE_DETECT_EN
                REG_TRIGGER: rdata_d = 32'(trigger_q);
`endif
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            pend_q     <= '0;
            enable_q   <= '0;
            claim_id_q <= '0;
            busy_q     <= 1'b0;
            meip_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= irq_i;
            sync2_q    <= sync1_q;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            claim_id_q <= claim_id_d;
            busy_q     <= busy_d;
            meip_q     <= meip_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef EXT_IRQ_EDGE_DETECT_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync3_q   <= '0;
            trigger_q <= '0;
        end else begin
            sync3_q   <= sync2_q;
            trigger_q <= trigger_d;
        end
    end
`endif

    assign meip_o  = meip_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: a vector table for the level-mode register and claim flow,
// plus hand-written sequences for sync latency, edge mode and asynchronous reset.
module tb_ext_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  irq_i;
    logic        ack_i;
    logic        meip_o;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic        wen_i;
    logic        ren_i;
    logic [31:0] rdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    ext_irq_ctrl #(.NUM_IRQ(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .irq_i   (irq_i),
        .ack_i   (ack_i),
        .meip_o  (meip_o),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wen_i   (wen_i),
        .ren_i   (ren_i),
        .rdata_o (rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  irq;
        logic        ack;
        logic        wen;
        logic        ren;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        chk_m;
        logic        exp_m;
        logic        chk_r;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[48];
    int   nv = 0;

    task automatic add(input logic [7:0] irq, input logic ack, input logic wen, input logic ren,
                       input logic [4:0] addr, input logic [31:0] wdata,
                       input logic chk_m, input logic exp_m,
                       input logic chk_r, input logic [31:0] exp_r);
        vecs[nv] = '{irq, ack, wen, ren, addr, wdata, chk_m, exp_m, chk_r, exp_r};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive strobes for one clock, then return them to idle at the following falling edge.
    task automatic step(input logic ack, input logic wen, input logic ren,
                        input logic [4:0] addr, input logic [31:0] wdata);
        ack_i   = ack;
        wen_i   = wen;
        ren_i   = ren;
        addr_i  = addr;
        wdata_i = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        ack_i = 1'b0;
        wen_i = 1'b0;
        ren_i = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'h00, 32'h0);
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        step(1'b0, 1'b0, 1'b1, addr, 32'h0);
        chk(name, rdata_o, exp);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        step(1'b0, 1'b1, 1'b0, addr, data);
    endtask

    initial begin
        logic [31:0] trig_exp;
`ifdef EXT_IRQ_EDGE_DETECT_EN
        trig_exp = 32'hFF;
`else
        trig_exp = 32'h0;
`endif
        //   irq    ack wen ren addr   wdata         chk_m exp_m chk_r exp_r
        add(8'hFF, 0, 0, 1, 5'h00, 32'h0,         1, 0, 1, 32'h0);          // 0 PENDING still 0
        add(8'hFF, 0, 0, 1, 5'h04, 32'h0,         0, 0, 1, 32'h0);          // 1 ENABLE
        add(8'hFF, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h0);          // 2 CLAIM
        add(8'hFF, 0, 0, 1, 5'h10, 32'h0,         1, 0, 1, 32'h0);          // 3 TRIGGER
        add(8'hFF, 0, 1, 0, 5'h04, 32'h01,        1, 0, 0, 32'h0);          // 4 ENABLE=01
        add(8'hFF, 0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 5 meip rises
        add(8'hFF, 0, 0, 1, 5'h00, 32'h0,         1, 1, 1, 32'hFF);         // 6 PENDING=FF
        add(8'h0C, 0, 1, 0, 5'h04, 32'h0C,        1, 1, 0, 32'h0);          // 7 ENABLE=0C
        add(8'h0C, 0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 8
        add(8'h0C, 0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 9
        add(8'h0C, 0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 10
        add(8'h0C, 1, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 11 ack -> ID 3
        add(8'h0C, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h8000_0003);  // 12 CLAIM
        add(8'h08, 0, 0, 0, 5'h00, 32'h0,         1, 0, 0, 32'h0);          // 13 drop irq[2]
        add(8'h08, 0, 0, 0, 5'h00, 32'h0,         1, 0, 0, 32'h0);          // 14
        add(8'h08, 0, 0, 0, 5'h00, 32'h0,         1, 0, 0, 32'h0);          // 15
        add(8'h08, 0, 1, 0, 5'h0C, 32'h3,         1, 0, 0, 32'h0);          // 16 COMPLETE=3
        add(8'h08, 0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 17 meip re-asserts
        add(8'h08, 1, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 18 ack -> ID 4
        add(8'h08, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h8000_0004);  // 19 CLAIM
        add(8'h08, 0, 1, 0, 5'h0C, 32'h5,         1, 0, 0, 32'h0);          // 20 COMPLETE=5 ignored
        add(8'h08, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h8000_0004);  // 21 still busy
        add(8'h08, 1, 0, 0, 5'h00, 32'h0,         1, 0, 0, 32'h0);          // 22 ack while busy
        add(8'h08, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h8000_0000);  // 23 CLAIM busy, ID 0
        add(8'h08, 0, 1, 0, 5'h0C, 32'h0,         1, 0, 0, 32'h0);          // 24 COMPLETE=0
        add(8'h08, 1, 0, 0, 5'h00, 32'h0,         1, 1, 0, 32'h0);          // 25 ack -> ID 4
        add(8'h08, 0, 1, 0, 5'h0C, 32'h4,         1, 0, 0, 32'h0);          // 26 COMPLETE=4
        add(8'h08, 0, 1, 0, 5'h04, 32'h0,         1, 1, 0, 32'h0);          // 27 ENABLE=0
        add(8'h08, 1, 0, 0, 5'h00, 32'h0,         1, 0, 0, 32'h0);          // 28 ack, no candidate
        add(8'h08, 0, 0, 1, 5'h08, 32'h0,         1, 0, 1, 32'h0);          // 29 CLAIM idle
        add(8'h08, 0, 1, 1, 5'h04, 32'hA5,        1, 0, 1, 32'h0);          // 30 write+read old
        add(8'h08, 0, 0, 1, 5'h05, 32'h0,         1, 0, 1, 32'hA5);         // 31 byte offset ignored
        add(8'h08, 0, 0, 1, 5'h14, 32'h0,         0, 0, 1, 32'h0);          // 32 unmapped
        add(8'h08, 0, 0, 1, 5'h04, 32'h0,         0, 0, 1, 32'hA5);         // 33
        add(8'h08, 0, 0, 1, 5'h0C, 32'h0,         0, 0, 1, 32'h0);          // 34 COMPLETE reads 0
        add(8'h08, 0, 1, 0, 5'h10, 32'hFF,        1, 0, 0, 32'h0);          // 35 TRIGGER write
        add(8'h08, 0, 0, 0, 5'h00, 32'h0,         1, 0, 1, 32'h0);          // 36 rdata held
        add(8'h08, 0, 0, 1, 5'h10, 32'h0,         1, 0, 1, trig_exp);       // 37 TRIGGER read
        add(8'h08, 0, 1, 0, 5'h00, 32'hFF,        1, 0, 0, 32'h0);          // 38 write RO ignored
        add(8'h08, 0, 0, 1, 5'h00, 32'h0,         1, 0, 1, 32'h08);         // 39 PENDING
        add(8'h08, 0, 1, 0, 5'h10, 32'h0,         1, 0, 0, 32'h0);          // 40 TRIGGER=0

        reset_i = 1'b0;
        irq_i   = 8'hFF;
        ack_i   = 1'b0;
        wen_i   = 1'b0;
        ren_i   = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset meip", 32'(meip_o), 32'h0);
        chk("reset rdata", rdata_o, 32'h0);
        reset_i = 1'b1;

        for (int i = 0; i < nv; i++) begin
            irq_i = vecs[i].irq;
            step(vecs[i].ack, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_m) chk($sformatf("vec%0d meip", i), 32'(meip_o), 32'(vecs[i].exp_m));
            if (vecs[i].chk_r) chk($sformatf("vec%0d rdata", i), rdata_o, vecs[i].exp_r);
        end

        // Synchronizer latency: meip_o must rise exactly on the 4th edge after irq_i rises.
        irq_i = 8'h00;
        wr(5'h04, 32'h01);
        repeat (4) idle();
        chk("latency idle meip", 32'(meip_o), 32'h0);
        irq_i = 8'h01;
        for (int e = 1; e <= 4; e++) begin
            idle();
            chk($sformatf("latency edge%0d meip", e), 32'(meip_o), (e == 4) ? 32'h1 : 32'h0);
        end

`ifdef EXT_IRQ_EDGE_DETECT_EN
        irq_i = 8'h00;
        repeat (4) idle();
        wr(5'h10, 32'h01);
        irq_i = 8'h01;
        idle();
        irq_i = 8'h00;
        repeat (2) idle();
        rd(5'h00, 32'h01, "edge pulse PENDING");
        chk("edge pulse meip", 32'(meip_o), 32'h1);
        step(1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
        rd(5'h00, 32'h00, "edge claimed PENDING");
        rd(5'h08, 32'h8000_0001, "edge CLAIM");
        irq_i = 8'h01;
        idle();
        irq_i = 8'h00;
        repeat (2) idle();
        rd(5'h00, 32'h01, "edge re-pend PENDING");
        chk("edge busy meip", 32'(meip_o), 32'h0);
        wr(5'h0C, 32'h1);
        chk("edge complete meip", 32'(meip_o), 32'h0);
        idle();
        chk("edge after complete meip", 32'(meip_o), 32'h1);
`endif

        // Asynchronous reset while a claim is outstanding.
        rd(5'h04, 32'h01, "pre-reset ENABLE");
        step(1'b1, 1'b0, 1'b0, 5'h00, 32'h0);
        chk("pre-reset meip", 32'(meip_o), 32'h1);
        irq_i = 8'hFF;
        #2;
        reset_i = 1'b0;
        #1;
        chk("async reset meip", 32'(meip_o), 32'h0);
        chk("async reset rdata", rdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        rd(5'h08, 32'h0, "post-reset CLAIM");
        rd(5'h04, 32'h0, "post-reset ENABLE");
        rd(5'h00, 32'h0, "post-reset PENDING");
        rd(5'h10, 32'h0, "post-reset TRIGGER");
        chk("post-reset meip", 32'(meip_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
